// File: rtl/cordic_pkg.sv
// Shared widths, FSM encodings and channel-count bounds for the CORDIC lane sequencer.
package cordic_pkg;

    localparam int CDW_DEFAULT    = 22;
    localparam int FDW_DEFAULT    = 32;
    localparam int NUM_CH_DEFAULT = 2;
    localparam int NUM_CH_MIN     = 2;
    localparam int NUM_CH_MAX     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/lane_capture_buffer.sv
// Holds one burst of per-channel targets and squares; written in one shot, read by channel index.
module lane_capture_buffer
    import cordic_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT,
    parameter int CDW    = CDW_DEFAULT,
    parameter int FDW    = FDW_DEFAULT,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  capture,
    input  logic [NUM_CH*CDW-1:0] values,
    input  logic [NUM_CH*FDW-1:0] squares,
    input  logic [CH_W-1:0]       rd_index,
    output logic [CDW-1:0]        rd_target,
    output logic [FDW-1:0]        rd_square
);

    logic [CDW-1:0] target_mem [NUM_CH];
    logic [FDW-1:0] square_mem [NUM_CH];

    // Pure data storage, so no reset: contents are only read after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NUM_CH; i++) begin
                target_mem[i] <= values[i*CDW +: CDW];
                square_mem[i] <= squares[i*FDW +: FDW];
            end
        end
    end

    assign rd_target = target_mem[rd_index];
    assign rd_square = square_mem[rd_index];

endmodule

// File: rtl/cordic_lane_sequencer.sv
// Serialises a burst of NUM_CH operands into a shared CORDIC pipeline and tags in-order returns.
// Optional macro CORDIC_SEQ_COLLECT_EN gathers each burst's results onto out_bus.
module cordic_lane_sequencer
    import cordic_pkg::*;
#(
    parameter int CORDIC_DATA_WIDTH = CDW_DEFAULT,
    parameter int FLOAT_DATA_WIDTH  = FDW_DEFAULT,
    parameter int NUM_CH            = NUM_CH_DEFAULT,
    parameter int CH_W              = $clog2(NUM_CH)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clk_en,
    input  logic                                start,
    input  logic [NUM_CH*CORDIC_DATA_WIDTH-1:0] in_values,
    input  logic [NUM_CH*FLOAT_DATA_WIDTH-1:0]  in_squares,
    output logic                                ready,
    output logic                                issue_valid,
    output logic [CORDIC_DATA_WIDTH-1:0]        issue_target,
    output logic [FLOAT_DATA_WIDTH-1:0]         issue_square,
    output logic [CH_W-1:0]                     issue_tag,
    input  logic                                ret_valid,
    input  logic [CORDIC_DATA_WIDTH-1:0]        ret_result,
    input  logic [FLOAT_DATA_WIDTH-1:0]         ret_squared,
    output logic                                out_valid,
    output logic [CORDIC_DATA_WIDTH-1:0]        out_result,
    output logic [FLOAT_DATA_WIDTH-1:0]         out_squared,
    output logic [CH_W-1:0]                     out_ch,
    output logic                                done,
    output logic                                err,
    output logic [NUM_CH*CORDIC_DATA_WIDTH-1:0] out_bus
);

    localparam int CDW = CORDIC_DATA_WIDTH;
    localparam int FDW = FLOAT_DATA_WIDTH;
    localparam int OW  = $clog2(NUM_CH + 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    seq_state_t      state, state_nxt;
    logic [CH_W-1:0] index, index_nxt;
    logic [OW-1:0]   outstanding;
    logic [CH_W-1:0] ret_cnt;
    logic            accept, issue_fire, ret_accept, ret_stray;
    logic [CDW-1:0]  buf_target, sel_target;
    logic [FDW-1:0]  buf_square, sel_square;

    lane_capture_buffer #(
        .NUM_CH (NUM_CH),
        .CDW    (CDW),
        .FDW    (FDW),
        .CH_W   (CH_W)
    ) u_capture (
        .clk       (clk),
        .capture   (accept),
        .values    (in_values),
        .squares   (in_squares),
        .rd_index  (index),
        .rd_target (buf_target),
        .rd_square (buf_square)
    );

    assign ready      = (state == ST_IDLE) && (outstanding == '0);
    assign ret_accept = ret_valid && (outstanding != '0);
    assign ret_stray  = ret_valid && (outstanding == '0);

    // Channel 0 goes out on the accepting edge straight from the inputs; the buffer serves the rest.
    always_comb begin
        state_nxt  = state;
        index_nxt  = index;
        accept     = 1'b0;
        issue_fire = 1'b0;
        sel_target = buf_target;
        sel_square = buf_square;
        case (state)
            ST_IDLE: begin
                if (start && clk_en && ready) begin
                    accept     = 1'b1;
                    issue_fire = 1'b1;
                    sel_target = in_values[CDW-1:0];
                    sel_square = in_squares[FDW-1:0];
                    index_nxt  = CH_W'(1);
                    state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (clk_en) begin
                    issue_fire = 1'b1;
                    if (index == LAST_CH) begin
                        index_nxt = '0;
                        state_nxt = ST_DRAIN;
                    end else begin
                        index_nxt = index + CH_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if ((outstanding == '0) || ((outstanding == OW'(1)) && ret_accept))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            index <= '0;
        end else begin
            state <= state_nxt;
            index <= index_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({issue_fire, ret_accept})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Issue stage: registered feed into the external pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid  <= 1'b0;
            issue_target <= '0;
            issue_square <= '0;
            issue_tag    <= '0;
        end else begin
            issue_valid <= issue_fire;
            if (issue_fire) begin
                issue_target <= sel_target;
                issue_square <= sel_square;
                issue_tag    <= index;
            end
        end
    end

    // Return stage: independent of clk_en so the pipeline never backs up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_squared <= '0;
            out_ch      <= '0;
            done        <= 1'b0;
            ret_cnt     <= '0;
            err         <= 1'b0;
        end else begin
            out_valid <= ret_accept;
            done      <= ret_accept && (ret_cnt == LAST_CH);
            err       <= err | ret_stray;
            if (ret_accept) begin
                out_result  <= ret_result;
                out_squared <= ret_squared;
                out_ch      <= ret_cnt;
                ret_cnt     <= (ret_cnt == LAST_CH) ? '0 : ret_cnt + CH_W'(1);
            end
        end
    end

`ifdef CORDIC_SEQ_COLLECT_EN
    logic [NUM_CH*CDW-1:0] collect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collect <= '0;
        end else if (ret_accept) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ret_cnt == CH_W'(i))
                    collect[i*CDW +: CDW] <= ret_result;
            end
        end
    end

    assign out_bus = collect;
`else
    assign out_bus = '0;
`endif

endmodule

// File: tb/tb_cordic_lane_sequencer.sv
// Scoreboard bench for cordic_lane_sequencer with a fixed-latency loopback pipeline model.
module tb_cordic_lane_sequencer;

    localparam int NCH  = 4;
    localparam int CDW  = 22;
    localparam int FDW  = 32;
    localparam int CHW  = 2;
    localparam int LAT  = 5;
    localparam logic [FDW-1:0] SQ_KEY = 32'h5A5A_5A5A;

    typedef struct {
        logic [CDW-1:0] res;
        logic [FDW-1:0] sq;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst, clk_en, start;
    logic [NCH*CDW-1:0]   in_values;
    logic [NCH*FDW-1:0]   in_squares;
    logic                 ready, issue_valid, out_valid, done, err;
    logic [CDW-1:0]       issue_target, out_result, ret_result;
    logic [FDW-1:0]       issue_square, out_squared, ret_squared;
    logic [CHW-1:0]       issue_tag, out_ch;
    logic                 ret_valid;
    logic [NCH*CDW-1:0]   out_bus;

    logic                 pipe_flush, man_ret;
    logic [CDW-1:0]       man_result;
    logic [LAT-1:0]       pv;
    logic [CDW-1:0]       pt [LAT];
    logic [FDW-1:0]       ps [LAT];

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cordic_lane_sequencer #(
        .CORDIC_DATA_WIDTH (CDW),
        .FLOAT_DATA_WIDTH  (FDW),
        .NUM_CH            (NCH),
        .CH_W              (CHW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .start        (start),
        .in_values    (in_values),
        .in_squares   (in_squares),
        .ready        (ready),
        .issue_valid  (issue_valid),
        .issue_target (issue_target),
        .issue_square (issue_square),
        .issue_tag    (issue_tag),
        .ret_valid    (ret_valid),
        .ret_result   (ret_result),
        .ret_squared  (ret_squared),
        .out_valid    (out_valid),
        .out_result   (out_result),
        .out_squared  (out_squared),
        .out_ch       (out_ch),
        .done         (done),
        .err          (err),
        .out_bus      (out_bus)
    );

    // Loopback pipeline: result = target + 1, squared = square ^ SQ_KEY, LAT cycles later.
    always @(posedge clk) begin
        if (pipe_flush) pv <= '0;
        else            pv <= {pv[LAT-2:0], issue_valid};
        pt[0] <= issue_target;
        ps[0] <= issue_square;
        for (int i = 1; i < LAT; i++) begin
            pt[i] <= pt[i-1];
            ps[i] <= ps[i-1];
        end
    end

    assign ret_valid   = pv[LAT-1] | man_ret;
    assign ret_result  = man_ret ? man_result : pt[LAT-1] + CDW'(1);
    assign ret_squared = ps[LAT-1] ^ SQ_KEY;

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; clk_en = 1'b0; man_ret = 1'b0; man_result = '0;
        pipe_flush = 1'b1; in_values = '0; in_squares = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({issue_valid, out_valid, done, err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {issue_valid, out_valid, done, err});
        end
        n_checks++;
        if (out_bus !== '0 || out_result !== '0 || issue_target !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got bus=%h res=%h tgt=%h expected 0", out_bus, out_result, issue_target);
        end
        rst = 1'b0;
        @(negedge clk);
        pipe_flush = 1'b0;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", ready);
        end
    endtask

    task automatic run_burst(input logic [NCH*CDW-1:0] vals, input logic [NCH*FDW-1:0] sqs,
                             input int gap_len, input bit inject_start);
        int exp_tag = 0;
        int n_out = 0;
        int gap_left = gap_len;
        int cyc = 0;
        bit prev_en;
        exp_t e;
        logic [NCH*CDW-1:0] exp_bus = '0;

        while (ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_start: got %b expected 1", ready);
        end
        in_values = vals; in_squares = sqs; start = 1'b1; clk_en = 1'b1; prev_en = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            e.res = vals[i*CDW +: CDW] + CDW'(1);
            e.sq  = sqs[i*FDW +: FDW] ^ SQ_KEY;
            exp_q.push_back(e);
        end
        cyc = 0;
        while (n_out < NCH && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                n_checks++;
                if (issue_valid !== 1'b1 || issue_tag !== '0) begin
                    n_fail++;
                    $display("FAIL first_issue_latency: got v=%b tag=%0d expected v=1 tag=0", issue_valid, issue_tag);
                end
            end
            if (!prev_en) begin
                n_checks++;
                if (issue_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gated_issue: got %b expected 0", issue_valid);
                end
            end
            if (issue_valid === 1'b1) begin
                n_checks++;
                if (exp_tag >= NCH || issue_tag !== CHW'(exp_tag)) begin
                    n_fail++;
                    $display("FAIL issue_tag: got %0d expected %0d", issue_tag, exp_tag);
                end else if (issue_target !== vals[exp_tag*CDW +: CDW] || issue_square !== sqs[exp_tag*FDW +: FDW]) begin
                    n_fail++;
                    $display("FAIL issue_data: got %h/%h expected %h/%h", issue_target, issue_square,
                             vals[exp_tag*CDW +: CDW], sqs[exp_tag*FDW +: FDW]);
                end
                exp_tag++;
            end
            if (out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_unexpected: got out_valid=1 expected empty scoreboard");
                end else begin
                    e = exp_q.pop_front();
                    if (out_result !== e.res || out_squared !== e.sq || out_ch !== CHW'(n_out)
                        || done !== (n_out == NCH-1)) begin
                        n_fail++;
                        $display("FAIL out_data: got res=%h sq=%h ch=%0d done=%b expected res=%h sq=%h ch=%0d done=%b",
                                 out_result, out_squared, out_ch, done, e.res, e.sq, n_out, (n_out == NCH-1));
                    end
`ifdef CORDIC_SEQ_COLLECT_EN
                    exp_bus[n_out*CDW +: CDW] = e.res;
`endif
                end
                n_out++;
                if (n_out == NCH) begin
                    n_checks++;
                    if (out_bus !== exp_bus) begin
                        n_fail++;
                        $display("FAIL out_bus_done: got %h expected %h", out_bus, exp_bus);
                    end
                end
            end else begin
                n_checks++;
                if (done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_without_valid: got %b expected 0", done);
                end
            end
            n_checks++;
            if (ready !== (n_out == NCH)) begin
                n_fail++;
                $display("FAIL ready_in_burst: got %b expected %b", ready, (n_out == NCH));
            end
            if (gap_left > 0 && exp_tag >= 1) begin
                clk_en = 1'b0;
                gap_left--;
            end else begin
                clk_en = 1'b1;
            end
            prev_en = clk_en;
            if (inject_start && exp_tag >= 1 && n_out == 0) begin
                start = 1'b1; in_values = ~vals; in_squares = ~sqs;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        n_checks++;
        if (n_out != NCH || exp_tag != NCH) begin
            n_fail++;
            $display("FAIL burst_complete: got issues=%0d outs=%0d expected %0d", exp_tag, n_out, NCH);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_bus !== exp_bus || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL out_bus_hold: got %h v=%b expected %h v=0", out_bus, out_valid, exp_bus);
        end
    endtask

    task automatic test_basic();
        run_burst({22'h000400, 22'h000300, 22'h000200, 22'h000100},
                  {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000}, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_burst({22'h3FFFFF, 22'h000000, 22'h2AAAAA, 22'h155555},
                  {32'hFFFF_FFFF, 32'h0000_0000, 32'hDEAD_BEEF, 32'h1234_5678}, 0, 1'b0);
    endtask

    task automatic test_clk_en_gap();
        run_burst({22'h0ABCDE, 22'h012345, 22'h3C0FFE, 22'h000777},
                  {32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404}, 2, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_burst({22'h111111, 22'h222222, 22'h333333, 22'h044444},
                  {32'hA0A0_A0A0, 32'hB0B0_B0B0, 32'hC0C0_C0C0, 32'hD0D0_D0D0}, 1, 1'b1);
    endtask

    task automatic test_stray_return();
        @(negedge clk);
        man_ret = 1'b1; man_result = 22'h1F1F1F;
        @(negedge clk);
        man_ret = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_return: got v=%b err=%b expected v=0 err=1", out_valid, err);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b v=%b expected err=1 v=0", err, out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL err_cleared: got err=%b ready=%b expected err=0 ready=1", err, ready);
        end
    endtask

    task automatic test_reset_mid_burst();
        int seen = 0;
        int cyc = 0;
        bit saw_out = 1'b0;
        in_values  = {22'h000040, 22'h000030, 22'h000020, 22'h000010};
        in_squares = {32'h4, 32'h3, 32'h2, 32'h1};
        start = 1'b1; clk_en = 1'b1;
        while (seen < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (issue_valid === 1'b1) seen++;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (seen != 2 || {issue_valid, out_valid, done, err} !== 4'b0000 || issue_tag !== '0
            || issue_target !== '0 || out_bus !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got issues=%0d flags=%b tag=%0d tgt=%h bus=%h expected 2 0000 0 0 0",
                     seen, {issue_valid, out_valid, done, err}, issue_tag, issue_target, out_bus);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_ready: got %b expected 1", ready);
        end
        repeat (12) begin
            @(negedge clk);
            if (out_valid === 1'b1) saw_out = 1'b1;
        end
        n_checks++;
        if (err !== 1'b1 || saw_out) begin
            n_fail++;
            $display("FAIL stale_return_err: got err=%b out_seen=%b expected err=1 out_seen=0", err, saw_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_clk_en_gap();
        test_start_ignored();
        test_stray_return();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cordic_lane_sequencer.md
CORDIC_LANE_SEQUENCER -- requirements
Module: cordic_lane_sequencer

Interface
REQ-001 SHALL have parameter CORDIC_DATA_WIDTH, default 22, fixed-point operand/result width.
REQ-002 SHALL have parameter FLOAT_DATA_WIDTH, default 32, square side-band width.
REQ-003 SHALL have parameter NUM_CH, default 2, channels per burst (legal 2..16); CH_W = clog2(NUM_CH).
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 clk_en  in  1  issue-side advance enable.
REQ-007 start  in  1  burst request.
REQ-008 in_values  in  NUM_CH*CORDIC_DATA_WIDTH  packed targets, channel 0 in LSBs.
REQ-009 in_squares  in  NUM_CH*FLOAT_DATA_WIDTH  packed squares, channel 0 in LSBs.
REQ-010 ready  out  1  high when a start is accepted.
REQ-011 issue_valid, issue_target, issue_square, issue_tag  out  1/CDW/FDW/CH_W  registered pipeline feed.
REQ-012 ret_valid, ret_result, ret_squared  in  1/CDW/FDW  in-order pipeline return.
REQ-013 out_valid, out_result, out_squared, out_ch  out  1/CDW/FDW/CH_W  registered per-channel result.
REQ-014 done  out  1  one-cycle pulse with last channel's result of a burst.
REQ-015 err  out  1  sticky unexpected-return flag.
REQ-016 out_bus  out  NUM_CH*CORDIC_DATA_WIDTH  collected burst results (see Configuration).

Function
REQ-017 States IDLE, ISSUE, DRAIN; ready = (state==IDLE) && (outstanding==0).
REQ-018 IDLE: start && clk_en && ready -> capture all in_values/in_squares, issue index=0, go ISSUE; start otherwise ignored.
REQ-019 ISSUE: each clk_en cycle drive issue_valid=1 with channel[index], issue_tag=index, index+1; after index NUM_CH-1 go DRAIN.
REQ-020 ISSUE with clk_en=0: issue_valid=0, index and captured data held; no channel skipped or duplicated.
REQ-021 First issue_valid appears the cycle after the accepting edge; NUM_CH issues take NUM_CH clk_en cycles.
REQ-022 outstanding counter (0..NUM_CH) +1 per issue, -1 per accepted return; simultaneous issue and return leave it unchanged.
REQ-023 Return side ignores clk_en; ret_valid with outstanding>0 -> next cycle out_valid=1, out_result/out_squared = return data, out_ch = return counter.
REQ-024 Return counter increments per accepted return, wraps NUM_CH-1 -> 0; done=1 on the wrap cycle coincident with out_valid.
REQ-025 ret_valid with outstanding==0 -> return dropped, no out_valid, err set until rst.
REQ-026 DRAIN -> IDLE when outstanding reaches 0 (same edge as last return accepted).

Reset
REQ-027 rst asserted at any time SHALL immediately force state IDLE, index 0, outstanding 0, return counter 0, and all outputs 0 except ready, which becomes 1 after release.
REQ-028 Reset mid-burst SHALL abandon the burst; later returns from the abandoned burst set err.

Configuration
REQ-029 Macro CORDIC_SEQ_COLLECT_EN defined: each accepted result written to out_bus slot out_ch; out_bus held stable from done until next burst's first out_valid.
REQ-030 CORDIC_SEQ_COLLECT_EN undefined: no collection storage; out_bus constant 0; all other behaviour identical.

Structure
REQ-031 Package cordic_pkg SHALL hold default widths, state encodings and the NUM_CH legal bounds.
REQ-032 One sub-module, lane_capture_buffer (burst capture plus indexed read), is natural; counters and FSM stay top-level.

Verification
REQ-033 NUM_CH=2, start with values 0x000100/0x000200, clk_en=1 -> issue tags 0,1 on consecutive cycles; ready low until both returned.
REQ-034 NUM_CH=4, clk_en low 2 cycles after first issue -> issue_valid low for those cycles, tags still 0,1,2,3 exactly once.
REQ-035 Loopback pipeline latency 5 -> out_ch 0..3 in order, done on out_ch=3, out_bus (COLLECT_EN) equals returned values.
REQ-036 ret_valid pulse in IDLE with nothing outstanding -> no out_valid, err=1 and stays 1.
REQ-037 rst asserted after 2 of 4 issues -> outputs 0 at once; after release ready=1; stale returns raise err.
REQ-038 start while ISSUE/DRAIN -> ignored, captured data unchanged.
